mmio_router: RTL
================

// Module: mmio_router
// PURPOSE
// - Parametrised memory-mapped I/O router between the core and the main RAM, UART and LED latch.
// - The core issues one request at a time and waits for a single-cycle done.
// - Adds a buffered UART receive path (RX FIFO), a status register and an error flag for unmapped addresses.
// - Uses a proper request/done handshake; there is no free-running load strobe.
// PARAMETERS
// - ADDR_W       32            core/memory address width
// - DATA_W       32            data width; multiple of 8
// - MEM_LATENCY  1             RAM read latency in cycles, >=1
// - UART_BASE    32'hFFFF_0000 UART window base; below it is RAM
// - LED_ADDR     32'hFFFF_0100 LED latch address
// - RX_DEPTH     16            RX FIFO entries; power of two, >=2
// - TIMEOUT_CYC  1000000       UART wait limit (only with MAP_TIMEOUT_EN)
// PORTS
// - clk      in   1         single clock
// - rst      in   1         synchronous reset, active-high
// - c_req    in   1         core request strobe; sampled only in IDLE
// - c_addr   in   ADDR_W    request address
// - c_din    in   DATA_W    write data
// - c_we     in   DATA_W/8  byte enables; nonzero = write, zero = read
// - c_dout   out  DATA_W    read data; valid while done=1
// - done     out  1         one-cycle completion pulse
// - err      out  1         valid with done; 1 = unmapped address or timeout
// - m_addr   out  ADDR_W    RAM address
// - m_din    out  DATA_W    RAM write data
// - m_we     out  DATA_W/8  RAM byte write enables
// - m_dout   in   DATA_W    RAM read data, MEM_LATENCY cycles after the address
// - t_data   out  8         UART TX byte
// - t_valid  out  1         one-cycle TX start pulse
// - tx_ready in   1         transmitter idle
// - tx_done  in   1         TX completion pulse
// - r_data   in   8         UART RX byte
// - rx_done  in   1         RX byte-valid pulse
// - led      out  8         LED latch
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, FIFO empty, overflow flag and counters cleared; any in-flight op is abandoned.
// - FSM states: IDLE, MEM, TX_RDY, TX_BUSY, RX_WAIT, DONE. done=1 only in DONE; DONE always returns to IDLE.
// - c_req outside IDLE is ignored. The core may raise the next c_req in the cycle after done.
// - Decode:
//   - c_addr < UART_BASE -> RAM
//   - UART_BASE+0 -> TX
//   - UART_BASE+4 -> RX
//   - UART_BASE+8 -> STATUS
//   - LED_ADDR -> LED
//   - anything else -> unmapped
// - RAM access:
//   - m_addr/m_din/m_we are driven in the accept cycle only; m_we=0 otherwise.
//   - MEM holds for MEM_LATENCY cycles, then m_dout is captured into c_dout.
//   - done follows MEM_LATENCY+1 cycles after c_req.
//   - RAM writes complete with the same latency; c_dout keeps its previous value on writes.
// - TX write:
//   - TX_RDY waits for tx_ready, then asserts t_valid for 1 cycle with t_data=c_din[7:0].
//   - TX_BUSY waits for tx_done; tx_done arriving outside TX_BUSY is ignored.
// - RX read:
//   - RX_WAIT pops the FIFO head once the FIFO is non-empty; c_dout={0,byte}.
//   - A byte pushed in cycle N can be popped at N+1 at the earliest.
// - STATUS read:
//   - c_dout={0, ovf, fifo_nonempty, tx_ready} (bits 2:0).
//   - Reading STATUS clears ovf.
// - LED: a write latches c_din[7:0]; a read returns {0,led}. done follows 1 cycle after c_req.
// - Writes to RX/STATUS and reads of TX have no effect, return c_dout=0 and err=0.
// - Unmapped access: no side effects, c_dout=0, err=1, done 1 cycle after c_req.
// - RX FIFO:
//   - rx_done pushes r_data regardless of FSM state.
//   - Push while full drops the byte and sets sticky ovf.
//   - Push and pop in the same cycle both succeed, including when full; the count stays the same.
//   - Pointers are log2(RX_DEPTH)+1 bits and wrap modulo 2*RX_DEPTH.
// CONFIGURATION
// - MAP_TIMEOUT_EN defined:
//   - A cycle counter runs in TX_RDY, TX_BUSY and RX_WAIT and clears on entry to each.
//   - At TIMEOUT_CYC the FSM goes to DONE with err=1 and c_dout=0. No t_valid is issued after a timeout.
// - MAP_TIMEOUT_EN undefined: the UART states wait indefinitely, and err is set only for unmapped addresses.
// TESTING
// - RAM write 0xDEADBEEF @0x40 (c_we=4'hF), then read @0x40 with MEM_LATENCY=2 -> done 3 cycles after c_req, c_dout=0xDEADBEEF, err=0.
// - Write 0x41 to UART_BASE with tx_ready=0 for 5 cycles -> no t_valid; on tx_ready: single t_valid with t_data=0x41; done 1 cycle after tx_done.
// - Push 17 bytes 0x00..0x10 via rx_done (RX_DEPTH=16) -> STATUS reads 0x6 (tx_ready=0), then 0x2 on the next read; 16 RX reads return 0x00..0x0F.
// - RX read on empty FIFO, byte 0x5A arrives 10 cycles later -> done with c_dout=0x5A; FIFO empty afterwards.
// - Read @UART_BASE+0xC -> done after 1 cycle, err=1, c_dout=0. LED write 0xA5 -> led=0xA5.
// - Assert rst mid TX_BUSY -> next cycle: done=0, t_valid=0, led=0, FIFO empty; with MAP_TIMEOUT_EN, TIMEOUT_CYC=8 and an RX read on empty FIFO -> err=1 on done 9 cycles after c_req.

Source files
------------

// File: rtl/mmio_router.sv
// MMIO router: core requests go to RAM, the UART (TX, buffered RX, status) or the LED latch.
// Define MAP_TIMEOUT_EN to bound the UART wait states by TIMEOUT_CYC cycles.
module mmio_router #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] UART_BASE   = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] LED_ADDR    = 32'hFFFF_0100,
  parameter int unsigned       RX_DEPTH    = 16,
  parameter int unsigned       TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_din,
  input  logic [DATA_W/8-1:0] c_we,
  output logic [DATA_W-1:0]   c_dout,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_din,
  output logic [DATA_W/8-1:0] m_we,
  input  logic [DATA_W-1:0]   m_dout,
  output logic [7:0]          t_data,
  output logic                t_valid,
  input  logic                tx_ready,
  input  logic                tx_done,
  input  logic [7:0]          r_data,
  input  logic                rx_done,
  output logic [7:0]          led
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(RX_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);

  localparam logic [ADDR_W-1:0] TX_ADDR = UART_BASE + ADDR_W'(0);
  localparam logic [ADDR_W-1:0] RX_ADDR = UART_BASE + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ST_ADDR = UART_BASE + ADDR_W'(8);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StMem    = 3'd1;
  localparam logic [2:0] StTxRdy  = 3'd2;
  localparam logic [2:0] StTxBusy = 3'd3;
  localparam logic [2:0] StRxWait = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [7:0]        byte_q, byte_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;
  logic [7:0]        led_q, led_d;

  logic [7:0]        rx_mem_q [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              ovf_q;
  logic              fifo_empty, fifo_full, push_ok, pop, ovf_clr;

  logic accept, is_wr, is_ram, is_tx, is_rx, is_st, is_led;
  logic tmo_hit;

  // Address decode
  assign is_ram = c_addr < UART_BASE;
  assign is_tx  = c_addr == TX_ADDR;
  assign is_rx  = c_addr == RX_ADDR;
  assign is_st  = c_addr == ST_ADDR;
  assign is_led = c_addr == LED_ADDR;
  assign is_wr  = |c_we;
  assign accept = !rst && (state_q == StIdle) && c_req;

  // Full when the pointers differ only in the wrap bit
  assign fifo_empty = wr_ptr_q == rd_ptr_q;
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign push_ok    = rx_done && (!fifo_full || pop);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    byte_d  = byte_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    err_d   = err_q;
    led_d   = led_q;
    pop     = 1'b0;
    ovf_clr = 1'b0;
    t_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          wr_d   = is_wr;
          byte_d = c_din[7:0];
          lat_d  = '0;
          if (is_ram) begin
            state_d = StMem;
          end else begin
            dout_d  = '0;
            state_d = StDone;
            if (is_tx) begin
              if (is_wr) state_d = StTxRdy;
            end else if (is_rx) begin
              if (!is_wr) state_d = StRxWait;
            end else if (is_st) begin
              if (!is_wr) begin
                dout_d[2:0] = {ovf_q, !fifo_empty, tx_ready};
                ovf_clr     = 1'b1;
              end
            end else if (is_led) begin
              if (is_wr) led_d = c_din[7:0];
              else       dout_d = DATA_W'(led_q);
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      StMem: begin
        if (lat_q == LAT_W'(MEM_LATENCY - 1)) begin
          if (!wr_q) dout_d = m_dout;
          state_d = StDone;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      StTxRdy: begin
        if (tx_ready) begin
          t_valid = 1'b1;
          state_d = StTxBusy;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StTxBusy: begin
        if (tx_done) begin
          state_d = StDone;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StRxWait: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          dout_d  = DATA_W'(rx_mem_q[rd_ptr_q[IDX_W-1:0]]);
          state_d = StDone;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      byte_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      byte_q  <= byte_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  // RX FIFO pointers and sticky overflow; a fresh overflow wins over a status-read clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      ovf_q <= (ovf_q && !ovf_clr) || (rx_done && fifo_full && !pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) rx_mem_q[wr_ptr_q[IDX_W-1:0]] <= r_data;
  end

`ifdef MAP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             in_wait;

  assign in_wait = (state_q == StTxRdy) || (state_q == StTxBusy) || (state_q == StRxWait);
  assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Restarts on every state change, so each wait state gets its own budget
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) tmo_q <= '0;
    else if (in_wait)                tmo_q <= tmo_q + TMO_W'(1);
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
`endif

  assign c_dout = dout_q;
  assign done   = state_q == StDone;
  assign err    = err_q;
  assign led    = led_q;
  assign t_data = t_valid ? byte_q : 8'h00;

  // RAM sees the request only in the accept cycle
  assign m_addr = (accept && is_ram) ? c_addr : '0;
  assign m_din  = (accept && is_ram) ? c_din  : '0;
  assign m_we   = (accept && is_ram) ? c_we   : BE_W'(0);

endmodule
